// File: rtl/cl_bram_wrapper_c.sv
// cl_bram_wrapper_c: the systolic array writes full result rows; the host reads them back one 32-bit lane at a time.
// Optional macro CL_C_LINE_BUF_EN adds a one-row read buffer so that consecutive lane reads of a row skip the BRAM.
module cl_bram_wrapper_c #(
  parameter int DATA_SIZE        = 32,
  parameter int SYSTOLIC_SIZE    = 2,
  parameter int MEMORY_DATA_SIZE = 64,
  parameter int DEPTH            = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        work,
  input  logic                        in_out,
  input  logic [31:0]                 memory_address_C,
  input  logic [MEMORY_DATA_SIZE-1:0] memory_out_c,
  input  logic                        rd_req,
  input  logic [31:0]                 rd_addr,
  output logic                        rd_busy,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATA_SIZE-1:0]        rd_data,
  output logic                        rd_err,
  output logic                        wr_ovf
);

  localparam int          LANE_W  = $clog2(SYSTOLIC_SIZE);
  localparam int          ROW_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef logic [SYSTOLIC_SIZE-1:0][DATA_SIZE-1:0] row_t;
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  row_t                 mem [DEPTH];
  row_t                 bram_q;
  state_t               state_q;
  logic [LANE_W-1:0]    lane_q;
  logic [DATA_SIZE-1:0] rdData_q;
  logic                 rdErr_q;
  logic                 wrOvf_q;

  logic                 wrReq;
  logic                 wrEn;
  logic                 wrDrop;
  logic [ROW_W-1:0]     wrRow;
  logic [31:0]          rdRow;
  logic [ROW_W-1:0]     rdIdx;
  logic [LANE_W-1:0]    rdLane;
  logic                 rdInRange;
  logic                 rdAcc;
  logic                 bramRdEn;

  assign wrReq     = work && in_out;
  assign wrEn      = wrReq && (memory_address_C < DEPTH_W);
  assign wrDrop    = wrReq && !(memory_address_C < DEPTH_W);
  assign wrRow     = memory_address_C[ROW_W-1:0];
  assign rdRow     = rd_addr >> LANE_W;
  assign rdIdx     = rdRow[ROW_W-1:0];
  assign rdLane    = rd_addr[LANE_W-1:0];
  assign rdInRange = rdRow < DEPTH_W;
  assign rdAcc     = rd_req && (state_q == IDLE);

`ifdef CL_C_LINE_BUF_EN
  row_t             lineData_q;
  logic [ROW_W-1:0] lineTag_q;
  logic             lineVld_q;
  logic [ROW_W-1:0] row_q;
  logic             stale_q;
  logic             lineHit;

  assign lineHit  = lineVld_q && (lineTag_q == rdIdx);
  assign bramRdEn = rdAcc && rdInRange && !lineHit;
`else
  assign bramRdEn = rdAcc && rdInRange;
`endif

  // Port A writes and port B reads share one block so a same-address read sees the old row.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrRow] <= memory_out_c;
    if (bramRdEn) bram_q <= mem[rdIdx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      rdData_q <= '0;
      rdErr_q  <= 1'b0;
      wrOvf_q  <= 1'b0;
`ifdef CL_C_LINE_BUF_EN
      lineData_q <= '0;
      lineTag_q  <= '0;
      lineVld_q  <= 1'b0;
      row_q      <= '0;
      stale_q    <= 1'b0;
`endif
    end else begin
      if (wrDrop) wrOvf_q <= 1'b1;
`ifdef CL_C_LINE_BUF_EN
      if (wrEn && lineVld_q && (wrRow == lineTag_q)) lineVld_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rdAcc) begin
            lane_q <= rdLane;
            if (!rdInRange) begin
              rdData_q <= '0;
              rdErr_q  <= 1'b1;
              state_q  <= RESP;
            end
`ifdef CL_C_LINE_BUF_EN
            else if (lineHit) begin
              rdData_q <= lineData_q[rdLane];
              rdErr_q  <= 1'b0;
              state_q  <= RESP;
            end else begin
              row_q   <= rdIdx;
              stale_q <= wrEn && (wrRow == rdIdx);
              state_q <= FETCH;
            end
`else
            else begin
              state_q <= FETCH;
            end
`endif
          end
        end
        FETCH: begin
          rdData_q <= bram_q[lane_q];
          rdErr_q  <= 1'b0;
          state_q  <= RESP;
`ifdef CL_C_LINE_BUF_EN
          // A write to this row in the accept or fetch cycle leaves the captured copy stale.
          lineData_q <= bram_q;
          lineTag_q  <= row_q;
          lineVld_q  <= !stale_q && !(wrEn && (wrRow == row_q));
`endif
        end
        RESP: begin
          if (rd_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_busy  = (state_q != IDLE);
  assign rd_valid = (state_q == RESP);
  assign rd_data  = rdData_q;
  assign rd_err   = rdErr_q;
  assign wr_ovf   = wrOvf_q;

endmodule

// File: tb/tb_cl_bram_wrapper_c.sv
// tb_cl_bram_wrapper_c: scoreboard bench for the result-side BRAM wrapper.
// Latency expectations follow CL_C_LINE_BUF_EN when it is defined for the build.
module tb_cl_bram_wrapper_c;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        work = 1'b0;
  logic        in_out = 1'b0;
  logic [31:0] memory_address_C = '0;
  logic [63:0] memory_out_c = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_busy;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_ovf;

`ifdef CL_C_LINE_BUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 2;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  cl_bram_wrapper_c dut (
    .clk(clk), .rst_n(rst_n), .work(work), .in_out(in_out),
    .memory_address_C(memory_address_C), .memory_out_c(memory_out_c),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err), .wr_ovf(wr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t popExp();
    exp_t e;
    e.data = 32'hxxxx_xxxx;
    e.err  = 1'bx;
    e.lat  = -99;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic sysWrite(input logic [31:0] row, input logic [63:0] data);
    @(negedge clk);
    work = 1'b1; in_out = 1'b1; memory_address_C = row; memory_out_c = data;
    @(negedge clk);
    work = 1'b0; in_out = 1'b0;
  endtask

  // Issues one read with rd_ready high; optionally a systolic write lands on the accept edge.
  task automatic doRead(input logic [31:0] addr, input logic doWr, input logic [31:0] wrRow,
                        input logic [63:0] wrData, output int lat, output logic [31:0] data,
                        output logic err);
    @(negedge clk);
    rd_addr = addr; rd_req = 1'b1; rd_ready = 1'b1;
    if (doWr) begin
      work = 1'b1; in_out = 1'b1; memory_address_C = wrRow; memory_out_c = wrData;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      rd_req = 1'b0; work = 1'b0; in_out = 1'b0;
    end while (!rd_valid && lat < 10);
    if (!rd_valid) lat = -1;
    data = rd_data;
    err  = rd_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++; if (rd_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", rd_busy); end
    testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", rd_valid); end
    testsRun++; if (rd_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data got %h want 0", rd_data); end
    testsRun++; if (rd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got %b want 0", rd_err); end
    testsRun++; if (wr_ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovf got %b want 0", wr_ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_miss_hit();
    int lat; logic [31:0] d; logic er; exp_t e;
    sysWrite(32'd5, {32'hBBBB_0002, 32'hAAAA_0001});
    sb.push_back('{32'hAAAA_0001, 1'b0, 2});
    doRead(32'd10, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL miss10_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL miss10_data got %h want %h", d, e.data); end
    testsRun++; if (er !== e.err) begin testsFailed++; $display("[TB] FAIL miss10_err got %b want %b", er, e.err); end
    sb.push_back('{32'hBBBB_0002, 1'b0, HIT_LAT});
    doRead(32'd11, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL hit11_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL hit11_data got %h want %h", d, e.data); end
    testsRun++; if (er !== e.err) begin testsFailed++; $display("[TB] FAIL hit11_err got %b want %b", er, e.err); end
  endtask

  task automatic test_backpressure();
    int lat; int extra; exp_t e;
    @(negedge clk);
    sb.push_back('{32'hAAAA_0001, 1'b0, HIT_LAT});
    rd_req = 1'b1; rd_addr = 32'd10; rd_ready = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_valid && lat < 10);
    if (!rd_valid) lat = -1;
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL bp_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (rd_data !== e.data) begin testsFailed++; $display("[TB] FAIL bp_data got %h want %h", rd_data, e.data); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 32'd11;
      @(negedge clk);
      testsRun++; if (rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_hold_valid cycle %0d got %b want 1", i, rd_valid); end
      testsRun++; if (rd_data !== e.data) begin testsFailed++; $display("[TB] FAIL bp_hold_data cycle %0d got %h want %h", i, rd_data, e.data); end
      testsRun++; if (rd_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_hold_busy cycle %0d got %b want 1", i, rd_busy); end
    end
    rd_ready = 1'b1;
    @(negedge clk);
    testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_release_valid got %b want 0", rd_valid); end
    sb.push_back('{32'hBBBB_0002, 1'b0, HIT_LAT});
    lat = 0;
    do begin @(negedge clk); lat++; rd_req = 1'b0; end while (!rd_valid && lat < 10);
    if (!rd_valid) lat = -1;
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL bp_next_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (rd_data !== e.data) begin testsFailed++; $display("[TB] FAIL bp_next_data got %h want %h", rd_data, e.data); end
    extra = 0;
    repeat (4) begin @(negedge clk); if (rd_valid) extra++; end
    testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL bp_extra_resp got %0d want 0", extra); end
  endtask

  task automatic test_invalidate();
    int lat; logic [31:0] d; logic er; exp_t e;
    sysWrite(32'd3, {32'h4, 32'h3});
    sb.push_back('{32'h3, 1'b0, 2});
    doRead(32'd6, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL inv_first_data got %h want %h", d, e.data); end
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL inv_first_lat got %0d want %0d", lat, e.lat); end
    sysWrite(32'd3, {32'h2, 32'h1});
    sb.push_back('{32'h1, 1'b0, 2});
    doRead(32'd6, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL inv_refetch_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL inv_refetch_data got %h want %h", d, e.data); end
    testsRun++; if (er !== e.err) begin testsFailed++; $display("[TB] FAIL inv_refetch_err got %b want %b", er, e.err); end
  endtask

  task automatic test_same_cycle();
    int lat; logic [31:0] d; logic er; exp_t e;
    sysWrite(32'd7, {32'h7777_0011, 32'h7777_0010});
    sb.push_back('{32'h7777_0010, 1'b0, 2});
    doRead(32'd14, 1'b1, 32'd7, {32'h8888_0021, 32'h8888_0020}, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL same_old_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL same_old_data got %h want %h", d, e.data); end
    sb.push_back('{32'h8888_0020, 1'b0, 2});
    doRead(32'd14, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL same_new_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL same_new_data got %h want %h", d, e.data); end
  endtask

  task automatic test_error_ovf();
    int lat; logic [31:0] d; logic er; exp_t e;
    sb.push_back('{32'h0, 1'b1, 1});
    doRead(32'd256, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL err_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL err_data got %h want %h", d, e.data); end
    testsRun++; if (er !== e.err) begin testsFailed++; $display("[TB] FAIL err_flag got %b want %b", er, e.err); end
    sysWrite(32'd72, {32'h7272_0001, 32'h7272_0000});
    testsRun++; if (wr_ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_before got %b want 0", wr_ovf); end
    sysWrite(32'd200, {32'hDEAD_0001, 32'hDEAD_0000});
    testsRun++; if (wr_ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_set got %b want 1", wr_ovf); end
    repeat (3) @(negedge clk);
    testsRun++; if (wr_ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_sticky got %b want 1", wr_ovf); end
    sb.push_back('{32'h7272_0000, 1'b0, 2});
    doRead(32'd144, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL ovf_bram_data got %h want %h", d, e.data); end
    testsRun++; if (er !== e.err) begin testsFailed++; $display("[TB] FAIL ovf_bram_err got %b want %b", er, e.err); end
  endtask

  task automatic test_reset_mid();
    int lat; int stray; logic [31:0] d; logic er; exp_t e;
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'd10; rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    testsRun++; if (rd_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_busy_fetch got %b want 1", rd_busy); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (rd_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_abort_busy got %b want 0", rd_busy); end
    testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_abort_valid got %b want 0", rd_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (5) begin @(negedge clk); if (rd_valid) stray++; end
    testsRun++; if (stray !== 0) begin testsFailed++; $display("[TB] FAIL mid_stray_resp got %0d want 0", stray); end
    testsRun++; if (wr_ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_ovf_cleared got %b want 0", wr_ovf); end
    sb.push_back('{32'hAAAA_0001, 1'b0, 2});
    doRead(32'd10, 1'b0, 32'd0, 64'd0, lat, d, er);
    e = popExp();
    testsRun++; if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL mid_after_lat got %0d want %0d", lat, e.lat); end
    testsRun++; if (d !== e.data) begin testsFailed++; $display("[TB] FAIL mid_after_data got %h want %h", d, e.data); end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_backpressure();
    test_invalidate();
    test_same_cycle();
    test_error_ovf();
    test_reset_mid();
    testsRun++;
    if (sb.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
